event_handshake_src: RTL and testbench
======================================

# event_handshake_src

Source-side companion to the destination-domain bit synchronizers. It converts single-cycle event pulses in the source clock domain into held four-phase request levels, one independent channel per bit. Each channel keeps its request stable until the matching acknowledge returns, so a synchronizer at the far end captures every event regardless of the clock ratio. The acknowledge bits are synchronized back into this domain by an external multi-bit synchronizer instance and arrive here already resynchronized.

## Interface
- DATA_WIDTH, 4, number of independent event channels (min 1)
- clk_src  input  1  source-domain clock; all logic on its rising edge
- rst_src  input  1  reset: synchronous, active-high
- event_in  input  DATA_WIDTH  per-channel single-cycle event pulse
- ack_sync  input  DATA_WIDTH  per-channel acknowledge, already synchronized into clk_src
- ovf_clr  input  DATA_WIDTH  per-channel clear of the sticky overflow flag
- req_out  output  DATA_WIDTH  per-channel request level; driven directly from a flop, no logic after the register
- busy  output  DATA_WIDTH  channel is not in IDLE, or has an event pending
- done  output  DATA_WIDTH  one-cycle pulse when a handshake completes
- overflow  output  DATA_WIDTH  sticky flag; set when an event is dropped

## Operation
- Each channel runs its own FSM with states IDLE, REQ and ACK_LOW; channels never interact.
- IDLE: req_out=0.
  - If an event is present (event_in or the pending latch) and ack_sync=0, go to REQ and clear pending.
  - If an event arrives while ack_sync=1 (stale ack, e.g. after reset), set pending and stay in IDLE.
- REQ: req_out=1. When ack_sync=1, go to ACK_LOW.
- ACK_LOW: req_out=0. When ack_sync=0, assert done for one cycle.
  - If pending=1, go directly to REQ and clear pending.
  - Otherwise go to IDLE.
- One-deep pending latch per channel:
  - An event_in arriving in REQ or ACK_LOW sets pending.
  - An event_in arriving while pending=1 and not consumed that cycle is dropped and sets overflow.
- Simultaneous consume and arrive: an event_in in the same cycle that pending is consumed (ACK_LOW→REQ, or IDLE→REQ) re-sets pending. It is not dropped.
- event_in in IDLE with ack_sync=0 and pending=0 launches directly; pending is not used.
- overflow is cleared by ovf_clr. If set and clear happen in the same cycle, set wins.
- busy = (state != IDLE) | pending.
- Reset (rst_src=1, any state): next cycle state=IDLE, req_out=0, done=0, overflow=0, pending=0. An in-flight handshake is abandoned. The destination must tolerate a request that drops early.

## Timing
- Launch latency: event_in at cycle n (IDLE, ack_sync=0) gives req_out=1 at n+1.
- Ack rise: ack_sync=1 sampled at cycle m in REQ gives req_out=0 at m+1.
- Completion: ack_sync=0 sampled at cycle k in ACK_LOW gives done=1 at k+1, only for that cycle.
  - With pending=1, req_out=1 also at k+1.
- Minimum handshake period: 4 cycles with an immediately responding ack; actual period is set by the round-trip synchronizer latency.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- A shared package holds `hs_state_e` (IDLE, REQ, ACK_LOW), 2-bit encoding, reused by the destination-side responder.
- Sub-module `event_handshake_chan` implements one channel: FSM, pending latch and overflow flag.
- The top level is a generate loop over DATA_WIDTH instances, plus an elaboration check that DATA_WIDTH >= 1.

## Test plan
- Single event: pulse event_in[0] at cycle 10 with ack held 0. Expect req_out[0]=1 at 11. Raise ack at 15; expect req_out[0]=0 at 16. Drop ack at 20; expect done[0]=1 at 21 only and busy[0]=0 at 21.
- Back-to-back events: pulse event_in[1] at 10 and again at 12, ack responding after 3 cycles. Expect two complete handshakes, the second req rising the same cycle as the first done, and overflow[1]=0.
- Overflow: three pulses on channel 2 at cycles 10, 11 and 12 while ack is stuck at 0. Expect overflow[2]=1 at 13. Assert ovf_clr[2] and set event_in[2] in the same cycle; expect overflow to stay 1 (set wins).
- Stale ack: assert reset while ack_sync[3]=1, release it, then pulse event_in[3]. Expect req_out[3]=0 until ack_sync[3] falls, then req_out[3]=1 the following cycle.
- Reset mid-handshake: assert rst_src while all four channels are in REQ. Expect req_out=4'b0000, overflow=0, busy=0 the next cycle.
- Channel independence: random events on all channels with per-channel random ack delays of 2–9 cycles. A scoreboard checks that the number of done pulses plus the number of drops equals the number of events, per channel.

Source files
------------

// File: rtl/event_handshake_src_pkg.sv
// Shared handshake types for the event handshake source and the
// destination-side responder.
package event_handshake_src_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACK_LOW = 2'd2
  } hs_state_e;

  localparam int unsigned MIN_DATA_WIDTH = 1;

endpackage

// File: rtl/event_handshake_chan.sv
// One four-phase request channel: FSM, one-deep pending latch and
// sticky overflow flag.
module event_handshake_chan
  import event_handshake_src_pkg::*;
(
  input  logic clk_src,
  input  logic rst_src,
  input  logic event_in,
  input  logic ack_sync,
  input  logic ovf_clr,
  output logic req_out,
  output logic busy,
  output logic done,
  output logic overflow
);

  hs_state_e state_q, state_d;
  logic      pend_q, pend_d;
  logic      req_q, req_d;
  logic      done_q, done_d;
  logic      ovf_q, ovf_d;
  logic      drop;

  always_ff @(posedge clk_src) begin
    if (rst_src) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      req_q   <= req_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    drop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!ack_sync && (event_in || pend_q)) begin
          // a pending event is consumed; a coincident arrival re-arms it
          state_d = REQ;
          pend_d  = pend_q & event_in;
        end else if (event_in) begin
          drop   = pend_q;
          pend_d = 1'b1;
        end
      end
      REQ: begin
        if (ack_sync) state_d = ACK_LOW;
        if (event_in) begin
          drop   = pend_q;
          pend_d = 1'b1;
        end
      end
      ACK_LOW: begin
        if (!ack_sync) begin
          state_d = pend_q ? REQ : IDLE;
          pend_d  = event_in;
        end else if (event_in) begin
          drop   = pend_q;
          pend_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    req_d  = (state_d == REQ);
    done_d = (state_q == ACK_LOW) && !ack_sync;
    ovf_d  = drop | (ovf_q & ~ovf_clr);
  end

  assign req_out  = req_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != IDLE) | pend_q;

endmodule

// File: rtl/event_handshake_src.sv
// Converts source-domain event pulses into held four-phase requests,
// one independent channel per bit.
module event_handshake_src
  import event_handshake_src_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk_src,
  input  logic                  rst_src,
  input  logic [DATA_WIDTH-1:0] event_in,
  input  logic [DATA_WIDTH-1:0] ack_sync,
  input  logic [DATA_WIDTH-1:0] ovf_clr,
  output logic [DATA_WIDTH-1:0] req_out,
  output logic [DATA_WIDTH-1:0] busy,
  output logic [DATA_WIDTH-1:0] done,
  output logic [DATA_WIDTH-1:0] overflow
);

  if (DATA_WIDTH < MIN_DATA_WIDTH) begin : g_bad_width
    $error("event_handshake_src: DATA_WIDTH must be >= 1");
  end

  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_chan
    event_handshake_chan u_chan (
      .clk_src  (clk_src),
      .rst_src  (rst_src),
      .event_in (event_in[g]),
      .ack_sync (ack_sync[g]),
      .ovf_clr  (ovf_clr[g]),
      .req_out  (req_out[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .overflow (overflow[g])
    );
  end

endmodule

// File: tb/tb_event_handshake_src.sv
// Directed checks plus a randomised multi-channel run against a
// four-phase ack responder.
module tb_event_handshake_src;

  logic       clk_src = 1'b0;
  logic       rst_src;
  logic [3:0] event_in;
  logic [3:0] ack_man;
  logic [3:0] ack_auto;
  logic [3:0] ack_sync;
  logic [3:0] ovf_clr;
  logic [3:0] req_out;
  logic [3:0] busy;
  logic [3:0] done;
  logic [3:0] overflow;
  logic       auto_ack;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt [4];
  int dly [4];
  int ev_cnt [4];
  int dn_cnt [4];
  int dr_cnt [4];

  event_handshake_src #(.DATA_WIDTH(4)) dut (
    .clk_src  (clk_src),
    .rst_src  (rst_src),
    .event_in (event_in),
    .ack_sync (ack_sync),
    .ovf_clr  (ovf_clr),
    .req_out  (req_out),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk_src = ~clk_src;

  assign ack_sync = auto_ack ? ack_auto : ack_man;

  // four-phase responder: follows each req after a random 2..9 cycles
  always @(posedge clk_src) begin
    for (int i = 0; i < 4; i++) begin
      if (!auto_ack) begin
        ack_auto[i] <= 1'b0;
        cnt[i]      <= 0;
      end else if (req_out[i] != ack_auto[i]) begin
        if (cnt[i] >= dly[i]) begin
          ack_auto[i] <= req_out[i];
          cnt[i]      <= 0;
          dly[i]      <= int'($urandom_range(9, 2));
        end else begin
          cnt[i] <= cnt[i] + 1;
        end
      end else begin
        cnt[i] <= 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_src);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_src  = 1'b1;
    event_in = '0;
    ovf_clr  = '0;
    tick();
    tick();
    rst_src = 1'b0;
  endtask

  initial begin
    auto_ack = 1'b0;
    ack_man  = '0;
    for (int i = 0; i < 4; i++) begin
      dly[i]    = 2;
      ev_cnt[i] = 0;
      dn_cnt[i] = 0;
      dr_cnt[i] = 0;
    end
    do_reset();
    chk("reset_req", req_out, 4'b0000);
    chk("reset_busy", busy, 4'b0000);
    chk("reset_done", done, 4'b0000);
    chk("reset_ovf", overflow, 4'b0000);

    // single event on channel 0
    event_in[0] = 1'b1;
    tick();
    event_in[0] = 1'b0;
    chk("single_req_rise", req_out[0], 1'b1);
    chk("single_busy", busy[0], 1'b1);
    repeat (3) tick();
    chk("single_req_hold", req_out[0], 1'b1);
    ack_man[0] = 1'b1;
    tick();
    chk("single_req_fall", req_out[0], 1'b0);
    chk("single_no_done", done[0], 1'b0);
    repeat (4) tick();
    ack_man[0] = 1'b0;
    tick();
    chk("single_done", done[0], 1'b1);
    chk("single_idle", busy[0], 1'b0);
    tick();
    chk("single_done_pulse", done[0], 1'b0);

    // back-to-back events on channel 1
    event_in[1] = 1'b1;
    tick();
    event_in[1] = 1'b0;
    chk("b2b_req1", req_out[1], 1'b1);
    tick();
    event_in[1] = 1'b1;
    tick();
    event_in[1] = 1'b0;
    chk("b2b_pending_req", req_out[1], 1'b1);
    tick();
    ack_man[1] = 1'b1;
    tick();
    chk("b2b_ack_low", req_out[1], 1'b0);
    chk("b2b_busy", busy[1], 1'b1);
    repeat (3) tick();
    ack_man[1] = 1'b0;
    tick();
    chk("b2b_done1", done[1], 1'b1);
    chk("b2b_req2", req_out[1], 1'b1);
    repeat (2) tick();
    ack_man[1] = 1'b1;
    tick();
    chk("b2b_req2_fall", req_out[1], 1'b0);
    repeat (2) tick();
    ack_man[1] = 1'b0;
    tick();
    chk("b2b_done2", done[1], 1'b1);
    chk("b2b_req_low", req_out[1], 1'b0);
    chk("b2b_idle", busy[1], 1'b0);
    chk("b2b_ovf", overflow[1], 1'b0);

    // overflow on channel 2 with ack stuck low
    event_in[2] = 1'b1;
    tick();
    tick();
    tick();
    event_in[2] = 1'b0;
    chk("ovf_set", overflow[2], 1'b1);
    event_in[2] = 1'b1;
    ovf_clr[2]  = 1'b1;
    tick();
    event_in[2] = 1'b0;
    chk("ovf_set_wins", overflow[2], 1'b1);
    tick();
    ovf_clr[2] = 1'b0;
    chk("ovf_cleared", overflow[2], 1'b0);
    ack_man[2] = 1'b1;
    tick();
    ack_man[2] = 1'b0;
    tick();
    chk("ovf_done1", done[2], 1'b1);
    chk("ovf_pending_req", req_out[2], 1'b1);
    ack_man[2] = 1'b1;
    tick();
    ack_man[2] = 1'b0;
    tick();
    chk("ovf_done2", done[2], 1'b1);
    chk("ovf_idle", busy[2], 1'b0);

    // stale ack on channel 3 across reset
    ack_man[3] = 1'b1;
    do_reset();
    event_in[3] = 1'b1;
    tick();
    event_in[3] = 1'b0;
    chk("stale_no_req", req_out[3], 1'b0);
    chk("stale_busy", busy[3], 1'b1);
    repeat (3) tick();
    chk("stale_hold", req_out[3], 1'b0);
    ack_man[3] = 1'b0;
    tick();
    chk("stale_req", req_out[3], 1'b1);
    chk("stale_ovf", overflow[3], 1'b0);

    // reset with every channel mid-handshake and overflowing
    do_reset();
    ack_man  = '0;
    event_in = 4'b1111;
    repeat (3) tick();
    event_in = '0;
    chk("mid_req_all", req_out, 4'b1111);
    chk("mid_ovf_all", overflow, 4'b1111);
    rst_src = 1'b1;
    tick();
    rst_src = 1'b0;
    chk("mid_rst_req", req_out, 4'b0000);
    chk("mid_rst_ovf", overflow, 4'b0000);
    chk("mid_rst_busy", busy, 4'b0000);
    chk("mid_rst_done", done, 4'b0000);

    // randomised run: done + drops must equal events per channel
    do_reset();
    auto_ack = 1'b1;
    ovf_clr  = 4'b1111;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        event_in[i] = ($urandom_range(5, 0) == 0);
        if (event_in[i]) ev_cnt[i]++;
      end
      tick();
      for (int i = 0; i < 4; i++) begin
        if (done[i]) dn_cnt[i]++;
        if (overflow[i]) dr_cnt[i]++;
      end
    end
    event_in = '0;
    begin
      int k;
      k = 0;
      while (k < 400 && (busy != 4'b0000 || req_out != 4'b0000
                         || ack_sync != 4'b0000)) begin
        tick();
        for (int i = 0; i < 4; i++) begin
          if (done[i]) dn_cnt[i]++;
          if (overflow[i]) dr_cnt[i]++;
        end
        k++;
      end
      chk("rand_drain", (k < 400), 1'b1);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      if (overflow[i]) dr_cnt[i]++;
      chk($sformatf("rand_sb_ch%0d", i), dn_cnt[i] + dr_cnt[i], ev_cnt[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
